// File: rtl/beta_irq_pkg.sv
// Shared constants and types for the Beta interrupt controller.
// Optional build macro used by beta_irq_ctrl: BETA_IRQ_SYNC_EN (2-flop src synchroniser).
package beta_irq_pkg;

  localparam int unsigned DATA_W = 32;

  // Register word offsets
  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_CLAIM   = 2'd2;
  localparam logic [1:0] REG_MODE    = 2'd3;

  // Controller state encoding
  localparam logic [1:0] IRQ_IDLE    = 2'd0;
  localparam logic [1:0] IRQ_ASSERT  = 2'd1;
  localparam logic [1:0] IRQ_SERVICE = 2'd2;

  // Claim ID meaning "no source"
  localparam int unsigned ID_NONE = 0;

  // Qualified register-slave access for one cycle
  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [1:0]        addr;
    logic [DATA_W-1:0] wdata;
  } reg_req_t;

endpackage

// File: rtl/beta_irq_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module beta_irq_prio_enc #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned IDX_W   = 5
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Scan from the top down so the lowest set index is the last to assign
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/beta_irq_ctrl.sv
// Prioritised interrupt controller driving the Beta core irq pin.
// Build macro: BETA_IRQ_SYNC_EN adds a 2-flop synchroniser on every src bit.
module beta_irq_ctrl
  import beta_irq_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned ID_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src,
  output logic               irq,
  input  logic               sel,
  input  logic               re,
  input  logic               we,
  input  logic [1:0]         addr,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata
);

  localparam logic [NUM_SRC-1:0] SRC_ONE = NUM_SRC'(1);

  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [ID_W-1:0]    active_id_q, active_id_d;
  logic [1:0]         state_q, state_d;
  logic               irq_q;

  logic [NUM_SRC-1:0] eligible;
  logic               win_valid;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W-1:0]    win_id;
  logic [NUM_SRC-1:0] w1c_mask;
  logic [NUM_SRC-1:0] claim_mask;
  logic [NUM_SRC-1:0] edge_next;
  logic               claim_take;
  logic               complete;
  reg_req_t           req;
  logic               unused_wdata;

`ifdef BETA_IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q, sync2_q;

  // Two-stage synchroniser for asynchronous request lines
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = src;
`endif

  assign req          = '{rd: sel & re, wr: sel & we, addr: addr, wdata: wdata};
  assign unused_wdata = ^req.wdata;

  assign eligible = pending_q & enable_q;

  beta_irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (ID_W)
  ) u_prio_enc (
    .req_i   (eligible),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  assign win_id     = win_idx + ID_W'(1);
  assign claim_take = req.rd && (req.addr == REG_CLAIM) && (state_q == IRQ_ASSERT) && win_valid;
  assign complete   = req.wr && (req.addr == REG_CLAIM) && (state_q == IRQ_SERVICE) &&
                      (req.wdata[ID_W-1:0] == active_id_q);

  // Pending/enable/mode next state; an edge set wins over any clear in the same cycle
  always_comb begin
    w1c_mask   = (req.wr && req.addr == REG_PENDING) ? req.wdata[NUM_SRC-1:0] : '0;
    claim_mask = claim_take ? (SRC_ONE << win_idx) : '0;
    edge_next  = (pending_q & ~(w1c_mask | claim_mask)) | (src_s & ~src_q);
    pending_d  = (mode_q & edge_next) | (~mode_q & src_s);
    enable_d   = (req.wr && req.addr == REG_ENABLE) ? req.wdata[NUM_SRC-1:0] : enable_q;
    mode_d     = (req.wr && req.addr == REG_MODE)   ? req.wdata[NUM_SRC-1:0] : mode_q;
  end

  // Claim/complete handshake state machine
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    case (state_q)
      IRQ_IDLE: begin
        if (|eligible) state_d = IRQ_ASSERT;
      end
      IRQ_ASSERT: begin
        if (claim_take) begin
          state_d     = IRQ_SERVICE;
          active_id_d = win_id;
        end else if (!win_valid) begin
          state_d = IRQ_IDLE;
        end
      end
      IRQ_SERVICE: begin
        if (complete) begin
          state_d     = IRQ_IDLE;
          active_id_d = ID_W'(ID_NONE);
        end
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  // State and register file
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IRQ_IDLE;
      active_id_q <= '0;
      pending_q   <= '0;
      enable_q    <= '0;
      mode_q      <= '0;
      src_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_id_q <= active_id_d;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      src_q       <= src_s;
      irq_q       <= (state_d == IRQ_ASSERT);
    end
  end

  assign irq = irq_q;

  // Combinational read mux; CLAIM content depends on the handshake state
  always_comb begin
    rdata = '0;
    if (req.rd) begin
      case (req.addr)
        REG_PENDING: rdata = DATA_W'(pending_q);
        REG_ENABLE:  rdata = DATA_W'(enable_q);
        REG_MODE:    rdata = DATA_W'(mode_q);
        default: begin
          if (state_q == IRQ_ASSERT && win_valid) rdata = DATA_W'(win_id);
          else if (state_q == IRQ_SERVICE)        rdata = DATA_W'(active_id_q);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beta_irq_ctrl.sv
// Self-checking bench for beta_irq_ctrl (vector table + scoreboard queue).
module tb_beta_irq_ctrl;
  import beta_irq_pkg::*;

`ifdef BETA_IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  localparam logic [1:0] NOP = 2'd0;
  localparam logic [1:0] RD  = 2'd1;
  localparam logic [1:0] WR  = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  src;
  logic        irq;
  logic        sel, re, we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  beta_irq_ctrl #(.NUM_SRC(8), .ID_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .src   (src),
    .irq   (irq),
    .sel   (sel),
    .re    (re),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  typedef struct {
    string       name;
    logic        rst_n;
    logic [7:0]  src;
    logic [1:0]  op;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_irq;
  } vec_t;

  vec_t t1[$];
  vec_t t2[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(string n, logic r, logic [7:0] s, logic [1:0] op,
                              logic [1:0] a, logic [31:0] wd, logic [31:0] er, logic ei);
    vec_t v;
    v.name = n; v.rst_n = r; v.src = s; v.op = op; v.addr = a;
    v.wdata = wd; v.exp_rdata = er; v.exp_irq = ei;
    return v;
  endfunction

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, record the expectation, compare after settling
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst   = v.rst_n;
    src   = v.src;
    sel   = (v.op != NOP);
    re    = v.op[0];
    we    = v.op[1];
    addr  = v.addr;
    wdata = v.wdata;
    sb.push_back(v);
    #2;
    e = sb.pop_front();
    check({e.name, "/rdata"}, rdata, e.exp_rdata);
    check({e.name, "/irq"}, 32'(irq), 32'(e.exp_irq));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;

    // Reset, register masking, scenario 2 setup
    t1.push_back(mk("rst_wr_en",    0, 8'hFF, WR,  REG_ENABLE,  32'hFF, 0, 0));
    t1.push_back(mk("rst_rd_en",    0, 8'hFF, RD,  REG_ENABLE,  0, 0, 0));
    t1.push_back(mk("rst_rd_pend",  0, 8'hFF, RD,  REG_PENDING, 0, 0, 0));
    t1.push_back(mk("rst_rd_mode",  0, 8'hFF, RD,  REG_MODE,    0, 0, 0));
    t1.push_back(mk("rst_rd_claim", 0, 8'hFF, RD,  REG_CLAIM,   0, 0, 0));
    t1.push_back(mk("release",      1, 8'h00, NOP, REG_PENDING, 0, 0, 0));
    t1.push_back(mk("en_wide_wr",   1, 8'h00, WR,  REG_ENABLE,  32'hFFFF_FFFF, 0, 0));
    t1.push_back(mk("en_wide_rd",   1, 8'h00, RD,  REG_ENABLE,  0, 32'hFF, 0));
    t1.push_back(mk("s2_mode",      1, 8'h00, WR,  REG_MODE,    32'h01, 0, 0));
    t1.push_back(mk("s2_en",        1, 8'h00, WR,  REG_ENABLE,  32'h01, 0, 0));

    // Scenario 2 tail (after irq seen), priority, level, race, reset mid-service
    t2.push_back(mk("s2_pend",       1, 8'h00, RD,  REG_PENDING, 0, 1, 1));
    t2.push_back(mk("s2_claim",      1, 8'h00, RD,  REG_CLAIM,   0, 1, 1));
    t2.push_back(mk("s2_pend_clr",   1, 8'h00, RD,  REG_PENDING, 0, 0, 0));
    t2.push_back(mk("s2_claim_svc",  1, 8'h00, RD,  REG_CLAIM,   0, 1, 0));
    t2.push_back(mk("s2_complete",   1, 8'h00, WR,  REG_CLAIM,   1, 0, 0));
    t2.push_back(mk("s2_idle_claim", 1, 8'h00, RD,  REG_CLAIM,   0, 0, 0));
`ifndef BETA_IRQ_SYNC_EN
    t2.push_back(mk("s3_mode",       1, 8'h00, WR,  REG_MODE,    32'hFF, 0, 0));
    t2.push_back(mk("s3_en",         1, 8'h00, WR,  REG_ENABLE,  32'hFF, 0, 0));
    t2.push_back(mk("s3_pulse",      1, 8'h24, NOP, REG_PENDING, 0, 0, 0));
    t2.push_back(mk("s3_wait",       1, 8'h00, NOP, REG_PENDING, 0, 0, 0));
    t2.push_back(mk("s3_claim1",     1, 8'h00, RD,  REG_CLAIM,   0, 3, 1));
    t2.push_back(mk("s3_pend",       1, 8'h00, RD,  REG_PENDING, 0, 32'h20, 0));
    t2.push_back(mk("s3_complete1",  1, 8'h00, WR,  REG_CLAIM,   3, 0, 0));
    t2.push_back(mk("s3_reidle",     1, 8'h00, NOP, REG_PENDING, 0, 0, 0));
    t2.push_back(mk("s3_claim2",     1, 8'h00, RD,  REG_CLAIM,   0, 6, 1));
    t2.push_back(mk("s3_complete2",  1, 8'h00, WR,  REG_CLAIM,   6, 0, 0));
    t2.push_back(mk("s3_pend_end",   1, 8'h00, RD,  REG_PENDING, 0, 0, 0));
    t2.push_back(mk("s4_mode",       1, 8'h00, WR,  REG_MODE,    0, 0, 0));
    t2.push_back(mk("s4_en",         1, 8'h10, WR,  REG_ENABLE,  32'h10, 0, 0));
    t2.push_back(mk("s4_wait",       1, 8'h10, NOP, REG_PENDING, 0, 0, 0));
    t2.push_back(mk("s4_claim",      1, 8'h10, RD,  REG_CLAIM,   0, 5, 1));
    t2.push_back(mk("s4_pend",       1, 8'h10, RD,  REG_PENDING, 0, 32'h10, 0));
    t2.push_back(mk("s4_complete",   1, 8'h10, WR,  REG_CLAIM,   5, 0, 0));
    t2.push_back(mk("s4_reidle",     1, 8'h10, NOP, REG_PENDING, 0, 0, 0));
    t2.push_back(mk("s4_reassert",   1, 8'h10, NOP, REG_PENDING, 0, 0, 1));
    t2.push_back(mk("s4_drop",       1, 8'h00, NOP, REG_PENDING, 0, 0, 1));
    t2.push_back(mk("s4_drop2",      1, 8'h00, NOP, REG_PENDING, 0, 0, 1));
    t2.push_back(mk("s4_idle",       1, 8'h00, RD,  REG_CLAIM,   0, 0, 0));
    t2.push_back(mk("s5_mode",       1, 8'h00, WR,  REG_MODE,    32'h02, 0, 0));
    t2.push_back(mk("s5_en",         1, 8'h00, WR,  REG_ENABLE,  32'h02, 0, 0));
    t2.push_back(mk("s5_race",       1, 8'h02, WR,  REG_PENDING, 32'h02, 0, 0));
    t2.push_back(mk("s5_pend",       1, 8'h02, RD,  REG_PENDING, 0, 32'h02, 0));
    t2.push_back(mk("s5_claim",      1, 8'h00, RD,  REG_CLAIM,   0, 2, 1));
    t2.push_back(mk("s5_bad_done",   1, 8'h00, WR,  REG_CLAIM,   7, 0, 0));
    t2.push_back(mk("s5_still_svc",  1, 8'h00, RD,  REG_CLAIM,   0, 2, 0));
    t2.push_back(mk("s5_svc_irq",    1, 8'h00, NOP, REG_PENDING, 0, 0, 0));
`endif
    t2.push_back(mk("s6_reset",      0, 8'h00, NOP, REG_PENDING, 0, 0, 0));
    t2.push_back(mk("s6_claim",      1, 8'h00, RD,  REG_CLAIM,   0, 0, 0));
    t2.push_back(mk("s6_en",         1, 8'h00, RD,  REG_ENABLE,  0, 0, 0));
    t2.push_back(mk("s6_mode",       1, 8'h00, RD,  REG_MODE,    0, 0, 0));

    rst = 1'b0; src = '0; sel = 1'b0; re = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);

    foreach (t1[i]) step(t1[i]);

    // Edge latency: one-cycle pulse on src[0], then count cycles until irq
    step(mk("s2_pulse", 1, 8'h01, NOP, REG_PENDING, 0, 0, 0));
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      src = '0;
      #2;
      if (irq === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("s2_latency", 32'(lat), 32'(LAT));

    foreach (t2[i]) step(t2[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/beta_irq_ctrl.md
Name: beta_irq_ctrl

Overview:
- Parametrised interrupt controller that generalises the Beta core's single `irq` input to NUM_SRC prioritised sources.
- Sits beside the Beta core; drives the core's `irq` pin.
- Software reaches it through a small memory-mapped register slave decoded from the data bus.
- Adds per-source enable, edge/level mode, a claim/complete handshake and fixed priority (index 0 highest).

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..31).
- ID_W, 5, width of the claim ID field. IDs are source index + 1; 0 means none.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- src  in  NUM_SRC  interrupt request lines.
- irq  out  1  interrupt request to the Beta core.
- sel  in  1  register slave selected this cycle.
- re  in  1  read strobe (qualified by sel).
- we  in  1  write strobe (qualified by sel).
- addr  in  2  word offset: 0=PENDING, 1=ENABLE, 2=CLAIM, 3=MODE.
- wdata  in  32  write data.
- rdata  out  32  read data; combinational from addr when sel&re, else 0.

Behaviour:
- Reset (rst=0 at a clk edge):
  - pending, enable, mode, src_q and active_id clear to 0.
  - State goes to IDLE, so irq=0.
- Mode bit per source: 1=edge, 0=level.
- Edge source pending bit:
  - Set at the edge where src & ~src_q is true; src_q is updated every cycle.
  - Cleared by a PENDING write with a 1 in that bit, or by a claim.
  - Set wins over clear when both happen in the same cycle.
- Level source pending bit: mirrors src each cycle. W1C and claim have no effect on it.
- eligible = pending & enable. Winner = lowest set index, found by the priority encoder.
- Register reads:
  - PENDING reads pending, zero-extended.
  - ENABLE and MODE are read/write; bits at NUM_SRC and above read 0 and ignore writes.
- FSM state IDLE:
  - irq=0.
  - Go to ASSERT at the next edge if eligible != 0.
  - A CLAIM read returns 0 with no side effect.
- FSM state ASSERT:
  - irq=1.
  - A CLAIM read returns winner+1 combinationally. At that edge: active_id is stored, the winner's pending bit is cleared if it is edge-mode, and the state goes to IN_SERVICE.
  - If eligible becomes 0 (enable cleared or level source dropped) without a claim, go to IDLE at the next edge.
- FSM state IN_SERVICE:
  - irq=0; no nesting.
  - A CLAIM read returns active_id with no side effect.
  - A CLAIM write with wdata[ID_W-1:0]==active_id completes: at the next edge go to IDLE and clear active_id.
  - A mismatched write is ignored.
- After completion, a still-eligible source re-raises irq 1 cycle after IDLE.
- Latency (no sync): src rises before edge E0 → pending set at E0 → ASSERT at E1 → irq high after E1, i.e. 2 cycles.
- Writes when sel&re&we are all set: the read side effect and the write both take effect.
- Reset mid-service: returns to IDLE with everything cleared. No state survives.

Optional Feature:
- Macro: BETA_IRQ_SYNC_EN.
- Defined: src passes through a 2-flop synchroniser per bit before edge detection and level mirroring. Latency becomes 4 cycles; the synchroniser flops reset to 0.
- Undefined: src is assumed synchronous to clk and used directly. Latency is 2 cycles.

Decomposition:
- Package beta_irq_pkg holds:
  - register offset constants REG_PENDING=2'd0, REG_ENABLE=2'd1, REG_CLAIM=2'd2, REG_MODE=2'd3;
  - the state encoding IRQ_IDLE / IRQ_ASSERT / IRQ_SERVICE;
  - the ID_NONE=0 constant.
- One sub-module, beta_irq_prio_enc: combinational, parametrised on NUM_SRC, outputs a valid flag and the lowest set index.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with src=8'hFF and enable=0xFF written → all registers read 0, irq=0.
2. Edge latency: mode=0x01, enable=0x01; pulse src[0] for 1 cycle at E0 → PENDING=0x01 after E0, irq=1 after E1. CLAIM read returns 1, PENDING=0, irq=0. Write CLAIM=1 → IDLE.
3. Priority: mode=0xFF, enable=0xFF; src[5] and src[2] pulsed in the same cycle → first claim returns 3. After completion irq re-asserts 1 cycle later and the claim returns 6.
4. Level source: mode=0, enable=0x10, src[4] held high → claim returns 5. Complete with src[4] still high → irq re-asserts. Drop src[4] while in ASSERT → IDLE next cycle, irq=0.
5. Set/clear race: edge on src[1] in the same cycle as a PENDING write of 0x02 → PENDING=0x02 afterwards. A bad completion (write CLAIM=7 while active_id=2) keeps irq=0 and leaves the state at IN_SERVICE.
6. Drive rst=0 during IN_SERVICE → IDLE, active_id=0; a claim read returns 0. Re-run scenario 2 with BETA_IRQ_SYNC_EN defined → irq high 4 cycles after src.
